// File: rtl/capp_search_sequencer.sv
// Search sequencer for a content-addressable cell array: drives one masked search per
// command, latches the responder set, reports its size and optionally streams indices.
module capp_search_sequencer #(
  parameter int WORDS  = 100,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1,
  parameter int IDXW   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_comparand,
  input  logic [WIDTH-1:0]   cmd_mask,
  input  logic               cmd_count_only,
  input  logic               abort,
  output logic [2*WIDTH-1:0] mismatch_lines,
  input  logic [WORDS-1:0]   match_lines,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDXW-1:0]    rsp_index,
  output logic               rsp_last,
  output logic [IDXW:0]      match_count,
  output logic               done,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SEARCH, RESOLVE, DONE} state_t;

  localparam logic [WORDS-1:0] ONE = WORDS'(1);

  state_t             state, state_nxt;
  logic [WORDS-1:0]   tag;
  logic [WORDS-1:0]   tag_low;
  logic [WORDS-1:0]   responders;
  logic [IDXW:0]      resp_count;
  logic               count_only;
  logic [3:0]         settle_cnt;
  logic               settled;

  function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] comp,
                                                input logic [WIDTH-1:0] mask);
    logic [2*WIDTH-1:0] lines;
    lines = '0;
    for (int j = 0; j < WIDTH; j++) begin
      lines[2*j+1] = mask[j] & ~comp[j];
      lines[2*j]   = mask[j] &  comp[j];
    end
    return lines;
  endfunction

  function automatic logic [IDXW:0] popcount(input logic [WORDS-1:0] v);
    logic [IDXW:0] n;
    n = '0;
    for (int i = 0; i < WORDS; i++) n = n + {{IDXW{1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [IDXW-1:0] lowest(input logic [WORDS-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) if (v[i]) idx = IDXW'(i);
    return idx;
  endfunction

  // match_lines flags mismatching words, so responders are its complement
  assign responders = ~match_lines;
  assign resp_count = popcount(responders);
  assign settled    = (settle_cnt == 4'(SETTLE - 1));
  assign tag_low    = tag & (~tag + ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_index = '0;
    rsp_last  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (abort)        state_nxt = DONE;
        else if (settled) state_nxt = (resp_count == '0 || count_only) ? DONE : RESOLVE;
      end
      RESOLVE: begin
        rsp_valid = 1'b1;
        rsp_index = lowest(tag);
        rsp_last  = (tag != '0) && ((tag & (tag - ONE)) == '0);
        if (abort || (rsp_ready && rsp_last)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_lines <= '0;
      tag            <= '0;
      match_count    <= '0;
      count_only     <= 1'b0;
      settle_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          mismatch_lines <= encode(cmd_comparand, cmd_mask);
          count_only     <= cmd_count_only;
          settle_cnt     <= '0;
        end
        SEARCH: begin
          if (abort) begin
            mismatch_lines <= '0;
            tag            <= '0;
          end else if (settled) begin
            mismatch_lines <= '0;
            tag            <= responders;
            match_count    <= resp_count;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RESOLVE: begin
          if (abort)          tag <= '0;
          else if (rsp_ready) tag <= tag & ~tag_low;
        end
        DONE: tag <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_capp_search_sequencer.sv
// Directed bench: behavioural cell array, reference responder list as scoreboard.
`timescale 1ns/1ps
module tb_capp_search_sequencer;
  localparam int WORDS  = 100;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 3;
  localparam int IDXW   = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_comparand;
  logic [WIDTH-1:0]   cmd_mask;
  logic               cmd_count_only;
  logic               abort;
  logic [2*WIDTH-1:0] mismatch_lines;
  logic [WORDS-1:0]   match_lines;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDXW-1:0]    rsp_index;
  logic               rsp_last;
  logic [IDXW:0]      match_count;
  logic               done;
  logic               busy;

  logic [WIDTH-1:0] words [WORDS];
  int checks = 0;
  int errors = 0;
  int sb[$];

  capp_search_sequencer #(.WORDS(WORDS), .WIDTH(WIDTH), .SETTLE(SETTLE), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_comparand(cmd_comparand), .cmd_mask(cmd_mask), .cmd_count_only(cmd_count_only),
    .abort(abort), .mismatch_lines(mismatch_lines), .match_lines(match_lines),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_index(rsp_index),
    .rsp_last(rsp_last), .match_count(match_count), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Array model: a word mismatches when a driven line disagrees with its stored bit
  always_comb begin
    match_lines = '0;
    for (int i = 0; i < WORDS; i++)
      for (int j = 0; j < WIDTH; j++)
        if ((mismatch_lines[2*j+1] && words[i][j]) || (mismatch_lines[2*j] && !words[i][j]))
          match_lines[i] = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string ctx);
    chk({ctx, "_lines"}, 64'(mismatch_lines), 64'd0);
    chk({ctx, "_count"}, 64'(match_count), 64'd0);
    chk({ctx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({ctx, "_rsp_last"}, 64'(rsp_last), 64'd0);
    chk({ctx, "_rsp_index"}, 64'(rsp_index), 64'd0);
    chk({ctx, "_done"}, 64'(done), 64'd0);
    chk({ctx, "_busy"}, 64'(busy), 64'd0);
    chk({ctx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // stall: cycles of rsp_ready low at start of RESOLVE (cmd_valid offered meanwhile)
  // abort_hs / rst_hs: completed handshakes before abort / reset (-1 = never)
  task automatic search(input logic [WIDTH-1:0] comp, input logic [WIDTH-1:0] mask,
                        input logic co, input int stall, input int abort_hs, input int rst_hs);
    logic [2*WIDTH-1:0] enc;
    int n_exp, hs, cyc, stalled;
    bit reset_hit;
    enc = '0; n_exp = 0; hs = 0; cyc = 0; stalled = 0; reset_hit = 0;
    sb.delete();
    for (int j = 0; j < WIDTH; j++) begin
      enc[2*j+1] = mask[j] & ~comp[j];
      enc[2*j]   = mask[j] & comp[j];
    end
    for (int i = 0; i < WORDS; i++)
      if (((words[i] ^ comp) & mask) == '0) begin sb.push_back(i); n_exp++; end

    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_comparand = comp; cmd_mask = mask; cmd_count_only = co;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_comparand = $urandom; cmd_mask = $urandom; cmd_count_only = ~co;
    for (int k = 1; k <= SETTLE; k++) begin
      chk("search_lines", 64'(mismatch_lines), 64'(enc));
      chk("search_busy", 64'(busy), 64'd1);
      chk("search_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("search_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("search_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("match_count", 64'(match_count), 64'(n_exp));
    chk("lines_after_capture", 64'(mismatch_lines), 64'd0);

    if (co || n_exp == 0) begin
      chk("done_direct", 64'(done), 64'd1);
      chk("rsp_valid_none", 64'(rsp_valid), 64'd0);
    end else begin
      while (!done) begin
        if (cyc > 400) begin chk("timeout_done", 64'(done), 64'd1); break; end
        if (sb.size() == 0) begin chk("extra_rsp", 64'(rsp_valid), 64'd0); break; end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_index", 64'(rsp_index), 64'(sb[0]));
        chk("rsp_last", 64'(rsp_last), 64'(sb.size() == 1));
        chk("resolve_lines", 64'(mismatch_lines), 64'd0);
        if (stalled < stall) begin rsp_ready = 1'b0; cmd_valid = 1'b1; stalled++; end
        else begin rsp_ready = 1'b1; cmd_valid = 1'b0; end
        abort = (hs == abort_hs);
        if (rsp_ready) begin void'(sb.pop_front()); hs++; end
        @(negedge clk);
        abort = 1'b0; cyc++;
        if (rst_hs >= 0 && hs == rst_hs) begin reset_hit = 1; break; end
      end
      if (reset_hit) begin
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_done", 64'(done), 64'd0);
          chk("post_rst_busy", 64'(busy), 64'd0);
        end
        return;
      end
      if (abort_hs >= 0) chk("abort_hs_count", 64'(hs), 64'(abort_hs + 1));
      else               chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("done_latency", 64'(cyc), 64'(hs + stall));
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("done_count_held", 64'(match_count), 64'(n_exp));
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_lines", 64'(mismatch_lines), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    words[0] = 456; words[1] = 457; words[2] = 1000; words[3] = 1000; words[4] = 457;
    for (int i = 5; i <= 98; i++) words[i] = WIDTH'(i);
    words[99] = 457;
    rst = 1'b1; cmd_valid = 1'b0; cmd_comparand = '0; cmd_mask = '0;
    cmd_count_only = 1'b0; abort = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_done", 64'(done), 64'd0);

    search(32'd457,  32'hFFFF_FFFF, 1'b0, 0, -1, -1);
    search(32'd1000, 32'hFFFF_FFFF, 1'b0, 3, -1, -1);
    search(32'd0,    32'hFFFF_FFFF, 1'b0, 0, -1, -1);
    search(32'd0,    32'h0000_0000, 1'b0, 0, -1, -1);
    search(32'd457,  32'hFFFF_FFFF, 1'b1, 0, -1, -1);
    search(32'd50,   32'hFFFF_FFF0, 1'b0, 0,  2, -1);
    search(32'd50,   32'hFFFF_FFF0, 1'b0, 0, -1,  2);
    search(32'd457,  32'hFFFF_FFFF, 1'b0, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
